// File: rtl/lvds_echo_pkg.sv
// Shared types and constants for the LVDS echo link tester: FSM states,
// link widths and the 8-bit LFSR step used to generate the test pattern.
package lvds_echo_pkg;

    localparam int NIB_W  = 4;
    localparam int BYTE_W = 8;

    // Feedback taps at bits 7, 5, 4 and 3
    localparam logic [BYTE_W-1:0] LFSR_TAPS    = 8'hB8;
    localparam logic [BYTE_W-1:0] DEFAULT_SEED = 8'h01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_HI,
        S_TX_LO,
        S_RX_HI,
        S_RX_LO,
        S_NEXT,
        S_DONE
    } state_t;

    function automatic logic [BYTE_W-1:0] lfsr_next(input logic [BYTE_W-1:0] q);
        return {q[BYTE_W-2:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lvds_echo_lfsr8.sv
// 8-bit Fibonacci LFSR pattern generator; load has priority over advance.
module lvds_echo_lfsr8
    import lvds_echo_pkg::*;
#(
    parameter logic [BYTE_W-1:0] RESET_SEED = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [BYTE_W-1:0] seed,
    input  logic              adv,
    output logic [BYTE_W-1:0] q
);

    logic [BYTE_W-1:0] q_q;
    logic [BYTE_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = seed;
        end else if (adv) begin
            q_d = lfsr_next(q_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= RESET_SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/lvds_echo_tester.sv
// Traffic source and echo checker for the 4-bit LVDS echo link: sends LFSR
// bytes as two nibbles, reassembles the echo, and counts mismatches/timeouts.
module lvds_echo_tester
    import lvds_echo_pkg::*;
#(
    parameter int                TIMEOUT_CYC = 1024,
    parameter logic [BYTE_W-1:0] SEED        = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        run_len,
    output logic [NIB_W-1:0]  tx_nib,
    output logic              tx_valid,
    input  logic              rdy_from_recv,
    input  logic [NIB_W-1:0]  rx_nib,
    input  logic              rx_valid,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_cnt,
    output logic [7:0]        led
);

    localparam int TOUT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TIMEOUT_CYC - 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t            state_q, state_d;
    logic              rdy_meta_q, rdy_s_q;
    logic [8:0]        remaining_q, remaining_d;
    logic [TOUT_W-1:0] tout_q, tout_d;
    logic [NIB_W-1:0]  hi_nib_q, hi_nib_d;
    logic [BYTE_W-1:0] echo_q, echo_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              pass_q, pass_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [NIB_W-1:0]  tx_nib_q, tx_nib_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        led_q, led_d;

    logic              lfsr_load;
    logic              lfsr_adv;
    logic [BYTE_W-1:0] lfsr_q;
    logic              xfer;
    logic [BYTE_W-1:0] rx_byte;

    lvds_echo_lfsr8 #(
        .RESET_SEED(SEED)
    ) u_lfsr (
        .clk  (clk),
        .reset(reset),
        .load (lfsr_load),
        .seed (SEED),
        .adv  (lfsr_adv),
        .q    (lfsr_q)
    );

    assign xfer    = tx_valid_q && rdy_s_q;
    assign rx_byte = {hi_nib_q, rx_nib};

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        tout_d      = tout_q;
        hi_nib_d    = hi_nib_q;
        echo_d      = echo_q;
        err_cnt_d   = err_cnt_q;
        pass_d      = pass_q;
        busy_d      = busy_q;
        tx_nib_d    = tx_nib_q;
        tx_valid_d  = 1'b0;
        lfsr_load   = 1'b0;
        lfsr_adv    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    lfsr_load   = 1'b1;
                    remaining_d = (run_len == 8'd0) ? 9'd256 : {1'b0, run_len};
                    err_cnt_d   = 8'd0;
                    pass_d      = 1'b0;
                    busy_d      = 1'b1;
                    tx_nib_d    = SEED[BYTE_W-1:NIB_W];
                    tx_valid_d  = 1'b1;
                    state_d     = S_TX_HI;
                end
            end
            S_TX_HI: begin
                tx_valid_d = 1'b1;
                if (xfer) begin
                    tx_nib_d = lfsr_q[NIB_W-1:0];
                    state_d  = S_TX_LO;
                end
            end
            S_TX_LO: begin
                if (xfer) begin
                    tout_d  = '0;
                    state_d = S_RX_HI;
                end else begin
                    tx_valid_d = 1'b1;
                end
            end
            S_RX_HI: begin
                if (rx_valid) begin
                    hi_nib_d = rx_nib;
                    tout_d   = '0;
                    state_d  = S_RX_LO;
                end else if (tout_q == TOUT_LAST) begin
                    err_cnt_d = sat_inc(err_cnt_q);
                    state_d   = S_NEXT;
                end else begin
                    tout_d = tout_q + 1'b1;
                end
            end
            S_RX_LO: begin
                if (rx_valid) begin
                    echo_d = rx_byte;
                    if (rx_byte != lfsr_q) begin
                        err_cnt_d = sat_inc(err_cnt_q);
                    end
                    state_d = S_NEXT;
                end else if (tout_q == TOUT_LAST) begin
                    err_cnt_d = sat_inc(err_cnt_q);
                    state_d   = S_NEXT;
                end else begin
                    tout_d = tout_q + 1'b1;
                end
            end
            S_NEXT: begin
                lfsr_adv    = 1'b1;
                remaining_d = remaining_q - 9'd1;
                if (remaining_q == 9'd1) begin
                    busy_d  = 1'b0;
                    pass_d  = (err_cnt_q == 8'd0);
                    state_d = S_DONE;
                end else begin
                    // High nibble of the advanced LFSR value is q[6:3] of the current one
                    tx_nib_d   = lfsr_q[BYTE_W-2:NIB_W-1];
                    tx_valid_d = 1'b1;
                    state_d    = S_TX_HI;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        done_d = (state_d == S_DONE);
        led_d  = busy_d ? echo_d : err_cnt_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rdy_meta_q  <= 1'b0;
            rdy_s_q     <= 1'b0;
            remaining_q <= '0;
            tout_q      <= '0;
            hi_nib_q    <= '0;
            echo_q      <= '0;
            err_cnt_q   <= '0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tx_nib_q    <= '0;
            tx_valid_q  <= 1'b0;
            led_q       <= '0;
        end else begin
            state_q     <= state_d;
            rdy_meta_q  <= rdy_from_recv;
            rdy_s_q     <= rdy_meta_q;
            remaining_q <= remaining_d;
            tout_q      <= tout_d;
            hi_nib_q    <= hi_nib_d;
            echo_q      <= echo_d;
            err_cnt_q   <= err_cnt_d;
            pass_q      <= pass_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tx_nib_q    <= tx_nib_d;
            tx_valid_q  <= tx_valid_d;
            led_q       <= led_d;
        end
    end

    assign tx_nib   = tx_nib_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_cnt  = err_cnt_q;
    assign led      = led_q;

endmodule

// File: tb/tb_lvds_echo_tester.sv
// Scoreboard bench for lvds_echo_tester: loopback echo with optional byte
// corruption, stalls, timeouts, stray strobes and a mid-run reset.
module tb_lvds_echo_tester;

    localparam int         TOUT   = 16;
    localparam logic [7:0] SEED_V = 8'h01;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] run_len = 8'd0;
    logic       rdy_from_recv = 1'b0;
    logic [3:0] rx_nib;
    logic       rx_valid;
    logic [3:0] tx_nib;
    logic       tx_valid;
    logic       busy, done, pass;
    logic [7:0] err_cnt, led;

    lvds_echo_tester #(
        .TIMEOUT_CYC(TOUT),
        .SEED       (SEED_V)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .run_len      (run_len),
        .tx_nib       (tx_nib),
        .tx_valid     (tx_valid),
        .rdy_from_recv(rdy_from_recv),
        .rx_nib       (rx_nib),
        .rx_valid     (rx_valid),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .err_cnt      (err_cnt),
        .led          (led)
    );

    always #5 clk = ~clk;

    typedef struct { logic [3:0] nib; logic [3:0] x; bit lo; bit echo; } txe_t;
    typedef struct { int due; logic [3:0] nib; bit lo; } echo_t;
    typedef struct { int cyc; logic [7:0] val; } ledc_t;
    typedef struct { logic [7:0] err; bit pass; } res_t;

    txe_t  exp_tx[$];
    echo_t echo_q[$];
    ledc_t led_chk[$];
    res_t  exp_res[$];

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         first_xfer = -1;
    int         done_seen = 0;
    logic [7:0] corrupt [256];
    logic [3:0] hi_echo = 4'd0;
    bit         stray_req = 1'b0;
    logic [3:0] stray_nib = 4'd0;
    logic       rdy_m1 = 1'b0, rdy_s_m = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Far-end ready as seen by the transmitter after two register stages
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_m1  <= 1'b0;
            rdy_s_m <= 1'b0;
        end else begin
            rdy_m1  <= rdy_from_recv;
            rdy_s_m <= rdy_m1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] q);
        logic fb;
        fb = q[7] ^ q[5] ^ q[4] ^ q[3];
        return ((q << 1) | {7'd0, fb}) & 8'hFF;
    endfunction

    task automatic clear_corrupt();
        for (int i = 0; i < 256; i++) corrupt[i] = 8'h00;
    endtask

    task automatic plan_run(input int n, input bit echo);
        logic [7:0] q;
        int errs;
        txe_t t;
        res_t r;
        q = SEED_V;
        errs = 0;
        for (int i = 0; i < n; i++) begin
            t.nib = q[7:4]; t.x = corrupt[i][7:4]; t.lo = 1'b0; t.echo = echo;
            exp_tx.push_back(t);
            t.nib = q[3:0]; t.x = corrupt[i][3:0]; t.lo = 1'b1; t.echo = echo;
            exp_tx.push_back(t);
            if (!echo || corrupt[i] != 8'h00) errs++;
            q = lfsr_step(q);
        end
        r.err  = (errs > 255) ? 8'd255 : 8'(errs);
        r.pass = (errs == 0);
        exp_res.push_back(r);
    endtask

    task automatic do_run(input logic [7:0] rl, input bit echo, input bit chk_start);
        int n;
        n = (rl == 8'd0) ? 256 : int'(rl);
        plan_run(n, echo);
        @(negedge clk);
        start = 1'b1;
        run_len = rl;
        @(negedge clk);
        start = 1'b0;
        if (chk_start) begin
            chk("busy_at_cycle1", busy, 1);
            chk("tx_valid_at_cycle1", tx_valid, 1);
            chk("tx_nib_at_cycle1", tx_nib, SEED_V[7:4]);
        end
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (exp_res.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (exp_res.size() != 0) begin
            fails++;
            $display("FAIL done_timeout: no done within %0d cycles, required a done pulse", budget);
            exp_res.delete();
            exp_tx.delete();
            echo_q.delete();
            led_chk.delete();
        end
        repeat (2) @(negedge clk);
        chk("tx_nibbles_left", exp_tx.size(), 0);
    endtask

    // Monitor: scoreboards tx nibbles, led captures and done results; also
    // plays the far end by echoing each transferred nibble three cycles later.
    initial begin
        txe_t  t;
        echo_t e;
        ledc_t l;
        res_t  r;
        rx_valid = 1'b0;
        rx_nib   = 4'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rx_valid = 1'b0;
            end else begin
                if (led_chk.size() > 0 && led_chk[0].cyc == cyc) begin
                    l = led_chk.pop_front();
                    chk("led_echo", led, l.val);
                end
                if (done) begin
                    done_seen++;
                    if (exp_res.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_done: done=1, required 0 (cycle %0d)", cyc);
                    end else begin
                        r = exp_res.pop_front();
                        chk("err_cnt_at_done", err_cnt, r.err);
                        chk("pass_at_done", pass, r.pass);
                        chk("busy_at_done", busy, 0);
                        chk("led_at_done", led, r.err);
                    end
                end
                if (tx_valid && rdy_s_m) begin
                    if (first_xfer < 0) first_xfer = cyc + 1;
                    if (exp_tx.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL extra_tx: nibble %0h sent, required none", tx_nib);
                    end else begin
                        t = exp_tx.pop_front();
                        chk("tx_nib", tx_nib, t.nib);
                        if (t.echo) begin
                            e.due = cyc + 4;
                            e.nib = tx_nib ^ t.x;
                            e.lo  = t.lo;
                            echo_q.push_back(e);
                        end
                    end
                end
                rx_valid = 1'b0;
                if (echo_q.size() > 0 && echo_q[0].due == cyc + 1) begin
                    e = echo_q.pop_front();
                    rx_valid = 1'b1;
                    rx_nib   = e.nib;
                    if (e.lo) begin
                        l.cyc = cyc + 1;
                        l.val = {hi_echo, e.nib};
                        led_chk.push_back(l);
                    end else begin
                        hi_echo = e.nib;
                    end
                end else if (stray_req) begin
                    rx_valid  = 1'b1;
                    rx_nib    = stray_nib;
                    stray_req = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int rise;
        int ds;
        clear_corrupt();
        repeat (3) @(negedge clk);
        chk("rst_tx_nib", tx_nib, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_led", led, 0);
        reset = 1'b0;
        rdy_from_recv = 1'b1;
        repeat (4) @(negedge clk);

        // Clean loopback, six bytes
        do_run(8'd6, 1'b1, 1'b1);
        wait_done(500);

        // Third echoed byte returns 05 instead of 04
        corrupt[2] = 8'h01;
        do_run(8'd4, 1'b1, 1'b0);
        wait_done(500);
        clear_corrupt();

        // No echo at all: every byte times out
        do_run(8'd2, 1'b0, 1'b0);
        wait_done(300);

        // Ready held low: first nibble must wait, stray rx strobe ignored
        rdy_from_recv = 1'b0;
        repeat (4) @(negedge clk);
        first_xfer = -1;
        do_run(8'd1, 1'b1, 1'b0);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!(tx_valid === 1'b1 && tx_nib === 4'd0)) ok = 1'b0;
            if (i == 5) begin
                stray_nib = 4'($urandom_range(0, 15));
                stray_req = 1'b1;
            end
        end
        chk("stall_tx_stable", ok, 1);
        rdy_from_recv = 1'b1;
        rise = cyc + 1;
        wait_done(300);
        chk("first_xfer_after_rise", first_xfer, rise + 2);

        // run_len = 0 means 256 bytes
        do_run(8'd0, 1'b1, 1'b0);
        wait_done(5000);

        // 256 corrupted bytes: error count saturates
        for (int i = 0; i < 256; i++) corrupt[i] = 8'($urandom_range(1, 255));
        do_run(8'd0, 1'b1, 1'b0);
        wait_done(5000);
        clear_corrupt();

        // Second start mid-run is ignored
        do_run(8'd6, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        start = 1'b1;
        run_len = 8'd3;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_ignored_start", busy, 1);
        wait_done(500);

        // Randomized runs with random per-byte corruption
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 24; i++)
                corrupt[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            do_run(8'($urandom_range(1, 24)), 1'b1, 1'b0);
            wait_done(1000);
        end
        clear_corrupt();

        // Reset mid-run aborts with no done pulse
        do_run(8'd10, 1'b1, 1'b0);
        repeat (15) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_tx_nib", tx_nib, 0);
        chk("midrst_tx_valid", tx_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_pass", pass, 0);
        chk("midrst_err_cnt", err_cnt, 0);
        chk("midrst_led", led, 0);
        @(posedge clk);
        #2;
        exp_tx.delete();
        exp_res.delete();
        echo_q.delete();
        led_chk.delete();
        stray_req = 1'b0;
        ds = done_seen;
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("no_done_after_reset", done_seen, ds);
        chk("idle_after_reset", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lvds_echo_tester.md
# lvds_echo_tester

Upstream traffic source and checker for the 4-bit LVDS echo link. It generates an 8-bit LFSR byte stream and splits each byte into two 4-bit nibbles for the link transmitter. It then collects the echoed nibbles returned by the far FPGA, compares each reassembled byte against the expected value, and counts mismatches. It reports pass/fail and drives the 8 board LEDs.

## Interface
Parameters:
- `TIMEOUT_CYC`, 1024: cycles to wait for each echoed nibble before declaring that byte lost.
- `SEED`, 8'h01: LFSR value loaded on `start`; must be nonzero.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse that begins a run; ignored while `busy`.
- `run_len`  in  8  bytes per run, sampled on `start`; 0 means 256.
- `tx_nib`  out  4  nibble presented to the link transmitter.
- `tx_valid`  out  1  `tx_nib` is valid.
- `rdy_from_recv`  in  1  far-end ready; asynchronous, synchronized internally.
- `rx_nib`  in  4  echoed nibble from the link receiver.
- `rx_valid`  in  1  single-cycle strobe qualifying `rx_nib`; already in the `clk` domain.
- `busy`  out  1  a run is in progress.
- `done`  out  1  one-cycle pulse at the end of a run.
- `pass`  out  1  the last run had zero errors; held until the next `start`.
- `err_cnt`  out  8  mismatches plus timeouts in the current or last run; saturates at 255.
- `led`  out  8  while `busy`: last reassembled echo byte; otherwise: `err_cnt`.

## Operation
- Reset values: `tx_nib`=0, `tx_valid`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `led`=0. FSM goes to IDLE; LFSR loads `SEED`.
- `rdy_from_recv` passes through a 2-flop synchronizer to give `rdy_s`. A nibble transfers on a cycle where `tx_valid && rdy_s`.
- LFSR next-state function: `{q[6:0], q[7]^q[5]^q[4]^q[3]}`. With `SEED`=01 the sequence is 01, 02, 04, 08, 11, 23, …
- FSM states:
  - IDLE: on `start`, load the LFSR with `SEED`, set `remaining`=`run_len` (0 → 256), clear `err_cnt` and `pass`, set `busy`, go to TX_HI.
  - TX_HI: drive `tx_nib`=`q[7:4]` with `tx_valid`=1. On transfer, go to TX_LO.
  - TX_LO: drive `tx_nib`=`q[3:0]`. On transfer, drop `tx_valid`, clear the timeout counter, go to RX_HI.
  - RX_HI: on `rx_valid`, capture the high nibble, clear the timeout counter, go to RX_LO.
  - RX_LO: on `rx_valid`, assemble the byte, update `led`, compare against `q`, go to NEXT.
  - In RX_HI and RX_LO, if the timeout counter reaches `TIMEOUT_CYC`-1, count one error and go to NEXT with `led` unchanged.
  - NEXT: advance the LFSR and decrement `remaining`. If `remaining` was 1, go to DONE; otherwise go to TX_HI.
  - DONE: pulse `done`, set `pass` = (`err_cnt`==0), clear `busy`, go to IDLE.
- Boundary rules:
  - A mismatch and a timeout each count exactly one error per byte.
  - `err_cnt` holds at 255 once saturated.
  - `rx_valid` outside RX_HI/RX_LO is dropped silently.
  - `start` while `busy` is ignored.
  - `rdy_s` falling while in TX_HI/TX_LO holds `tx_valid` and `tx_nib` stable; the nibble is not skipped.
  - Reset asserted mid-run aborts the run immediately with no `done` pulse.

## Timing
- `start` at cycle 0 → `busy` and `tx_valid` high at cycle 1.
- The TX_LO transfer cycle is followed by RX_HI in the next cycle.
- An `rx_valid` in that same next cycle is accepted.
- `rdy_from_recv` rising → `rdy_s` high 2 cycles later.
- Last RX_LO capture → NEXT, then DONE: `done`, `pass`, and `busy`=0 all change 2 cycles after the capture.
- `led` and `err_cnt` update in the cycle after the RX_LO capture, or after the timeout.
- All outputs are registered.

## Structure
- Package `lvds_echo_pkg`: FSM state enum, `NIB_W`=4, `BYTE_W`=8, LFSR tap mask constant, default seed.
- One sub-module, `lvds_echo_lfsr8`, with ports `clk`, `reset`, `load`, `seed`, `adv`, `q`.
- Synchronizer, FSM, timeout counter, and error counter stay in the top module.

## Test plan
- Loopback (`rx` mirrors each accepted `tx` nibble 3 cycles later), `rdy_from_recv`=1, `run_len`=6:
  - `tx_nib` sequence is 0,1, 0,2, 0,4, 0,8, 1,1, 2,3.
  - `done` pulses once; `pass`=1; `err_cnt`=0.
- Loopback with bit 0 of the 3rd echoed byte flipped (05 returned instead of 04), `run_len`=4:
  - `err_cnt`=1, `pass`=0.
  - `led` shows 05 after the 3rd byte's capture.
- No echo, `TIMEOUT_CYC`=16, `run_len`=2:
  - Each byte times out; `err_cnt`=2.
  - `done` arrives in bounded time; `tx` sends exactly 4 nibbles.
- Hold `rdy_from_recv`=0 for 20 cycles, then raise it:
  - `tx_valid`=1 with `tx_nib`=0 stays stable the whole time.
  - The first transfer occurs 2 cycles after the rise.
- `run_len`=0 with loopback:
  - Exactly 256 bytes checked; `done` once; `err_cnt`=0.
- Extra checks:
  - A second `start` mid-run is ignored.
  - Reset mid-run returns all outputs to reset values with no `done` pulse.
  - A stray `rx_valid` while in TX_HI leaves `err_cnt` unchanged.
